// File: rtl/pipe_stream_fifo.sv
// Stream FIFO behind an enable-stalled delay line; optional stats via PIPE_STREAM_FIFO_STATS_EN.
// Latency: a word written at edge N is on dout with out_valid in cycle N+1 (first-word-fall-through).
// Backpressure: registered pipe_ena drops when full, so upstream freezes rather than dropping samples.
module pipe_stream_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AFULL = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             din,
    output logic                         pipe_ena,
    output logic [WIDTH-1:0]             dout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
`ifdef PIPE_STREAM_FIFO_STATS_EN
    output logic [$clog2(DEPTH+1)-1:0]   max_level,
    output logic [31:0]                  stall_cnt,
`endif
    output logic                         almost_full
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (DEPTH < 2) begin : g_bad_depth
            $error("pipe_stream_fifo: DEPTH must be at least 2");
        end
        if (AFULL < 1 || AFULL > DEPTH) begin : g_bad_afull
            $error("pipe_stream_fifo: AFULL must lie within 1..DEPTH");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr_next;
    logic [PW-1:0]    wr_ptr_next;
    logic [LW-1:0]    level_next;
    logic             wr;
    logic             rd;

    assign wr = in_valid & pipe_ena;
    assign rd = out_valid & out_ready;

    // Explicit wrap keeps non-power-of-two depths correct.
    always_comb begin
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        level_next  = level;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (rd) begin
                rd_ptr_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            if (wr) begin
                wr_ptr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            level_next = level + LW'(wr) - LW'(rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
            pipe_ena    <= 1'b1;
        end else begin
            rd_ptr      <= rd_ptr_next;
            wr_ptr      <= wr_ptr_next;
            level       <= level_next;
            out_valid   <= (level_next != '0);
            almost_full <= (level_next >= LW'(AFULL));
            pipe_ena    <= (level_next < LW'(DEPTH));
        end
    end

    // Storage carries no reset; content is only meaningful under out_valid.
    always_ff @(posedge clk) begin
        if (wr && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

`ifdef PIPE_STREAM_FIFO_STATS_EN
    // Statistics survive flush; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_level <= '0;
            stall_cnt <= '0;
        end else begin
            if (level_next > max_level) begin
                max_level <= level_next;
            end
            if (!pipe_ena && in_valid && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
